// File: rtl/mylogic_sweeper_pkg.sv
// rtl/mylogic_sweeper_pkg.sv - shared state encodings and sizes for the mylogic sweeper
package mylogic_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;

endpackage

// File: rtl/sweep_dwell_timer.sv
// rtl/sweep_dwell_timer.sv - 8-bit dwell counter, expired when count reaches DWELL-1
module sweep_dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 8'(DWELL - 1));

endmodule

// File: rtl/mylogic_sweeper.sv
// rtl/mylogic_sweeper.sv - sweeps mylogic through all {a,b,c} vectors and captures its truth table
// Optional result comparator is compiled in with MYLOGIC_SWEEP_COMPARE_EN.
module mylogic_sweeper #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       q_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth
`ifdef MYLOGIC_SWEEP_COMPARE_EN
  ,
  input  logic [7:0] expected,
  output logic [7:0] mismatch,
  output logic       pass
`endif
);

  import mylogic_sweeper_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic [7:0]       truth_q, truth_d;
  logic             expired;
  logic             accept;

  sweep_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ST_DRIVE),
    .run     (state_q == ST_DRIVE),
    .expired (expired)
  );

  assign accept = (state_q == ST_IDLE) && start && !abort;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    truth_d = truth_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          truth_d = '0;
          idx_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // The bit is captured even when abort lands in this cycle.
        truth_d[idx_q] = q_in;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    vec_d = ((state_d == ST_DRIVE) || (state_d == ST_SAMPLE)) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      truth_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      truth_q <= truth_d;
    end
  end

  assign a     = vec_q[2];
  assign b     = vec_q[1];
  assign c     = vec_q[0];
  assign busy  = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done  = (state_q == ST_DONE);
  assign truth = truth_q;

`ifdef MYLOGIC_SWEEP_COMPARE_EN
  logic [7:0] exp_q;
  logic [7:0] mismatch_q;
  logic       pass_q;

  // Result registers load on entry to DONE so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q      <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      if (accept) begin
        exp_q <= expected;
      end
      if ((state_q == ST_SAMPLE) && (state_d == ST_DONE)) begin
        mismatch_q <= truth_d ^ exp_q;
        pass_q     <= (truth_d == exp_q);
      end
    end
  end

  assign mismatch = mismatch_q;
  assign pass     = pass_q;
`endif

endmodule

// File: tb/tb_mylogic_sweeper.sv
// tb/tb_mylogic_sweeper.sv - randomized self-checking bench for mylogic_sweeper
module tb_mylogic_sweeper;

  localparam int D2   = 2;
  localparam int D4   = 4;
  localparam int NVEC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start2 = 1'b0, abort2 = 1'b0;
  logic       a2, b2, c2, q2, busy2, done2;
  logic [7:0] truth2;
  logic       start4 = 1'b0, abort4 = 1'b0;
  logic       a4, b4, c4, q4, busy4, done4;
  logic [7:0] truth4;

  logic [7:0] tbl2 = 8'h00;
  logic       rand_tbl = 1'b0;

  assign q2 = rand_tbl ? tbl2[{a2, b2, c2}] : ((a2 & b2) | c2);
  assign q4 = (a4 & b4) | c4;

`ifdef MYLOGIC_SWEEP_COMPARE_EN
  logic [7:0] expected2 = 8'h00, mismatch2, expected4 = 8'h00, mismatch4;
  logic       pass2, pass4;
`endif

  mylogic_sweeper #(.DWELL(D2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .abort (abort2),
    .a     (a2),
    .b     (b2),
    .c     (c2),
    .q_in  (q2),
    .busy  (busy2),
    .done  (done2),
    .truth (truth2)
`ifdef MYLOGIC_SWEEP_COMPARE_EN
    ,
    .expected (expected2),
    .mismatch (mismatch2),
    .pass     (pass2)
`endif
  );

  mylogic_sweeper #(.DWELL(D4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .abort (abort4),
    .a     (a4),
    .b     (b4),
    .c     (c4),
    .q_in  (q4),
    .busy  (busy4),
    .done  (done4),
    .truth (truth4)
`ifdef MYLOGIC_SWEEP_COMPARE_EN
    ,
    .expected (expected4),
    .mismatch (mismatch4),
    .pass     (pass4)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_truth = 8'h00;
  logic [7:0] m_mm    = 8'h00;
  logic       m_pass  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_q(input int v);
    logic [2:0] x;
    x = v[2:0];
    return rand_tbl ? tbl2[x] : ((x[2] & x[1]) | x[0]);
  endfunction

  // Model: sweep cycle k shows vector k/(D+1); the last cycle of each vector is the capture.
  task automatic sweep2(input int abort_cyc, input int noise_pct, input int rst_cyc,
                        input logic [7:0] exp_in);
    int len;
    int v;
    int ph;
    bit stop;
    bit was_rst;
    len = NVEC * (D2 + 1);
`ifdef MYLOGIC_SWEEP_COMPARE_EN
    expected2 = exp_in;
`endif
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
`ifdef MYLOGIC_SWEEP_COMPARE_EN
    expected2 = 8'($urandom);
`endif
    m_truth = 8'h00;
    stop    = 1'b0;
    was_rst = 1'b0;
    for (int k = 0; k <= len + 1 && !stop; k++) begin
      v = k / (D2 + 1);
      ph = k % (D2 + 1);
      abort2 = (k == abort_cyc);
      rst_n  = !(k == rst_cyc);
      start2 = (k <= len) && (k != abort_cyc) && (k != rst_cyc) &&
               ($urandom_range(0, 99) < noise_pct);
      check("busy", 32'(busy2), 32'(k < len));
      check("done", 32'(done2), 32'(k == len));
      check("vec", {29'b0, a2, b2, c2}, (k < len) ? 32'(v) : 32'd0);
      check("truth", 32'(truth2), 32'(m_truth));
`ifdef MYLOGIC_SWEEP_COMPARE_EN
      if (k == len) begin
        m_mm   = m_truth ^ exp_in;
        m_pass = (m_truth == exp_in);
      end
      check("mismatch", 32'(mismatch2), 32'(m_mm));
      check("pass", 32'(pass2), 32'(m_pass));
`endif
      if (k < len && ph == D2) m_truth[v[2:0]] = ref_q(v);
      tick();
      if (k == rst_cyc) was_rst = 1'b1;
      if (k == abort_cyc || k == rst_cyc) stop = 1'b1;
    end
    start2 = 1'b0;
    abort2 = 1'b0;
    rst_n  = 1'b1;
    if (was_rst) begin
      m_truth = 8'h00;
      m_mm    = 8'h00;
      m_pass  = 1'b0;
    end
    repeat (3) begin
      check("idle_busy", 32'(busy2), 32'd0);
      check("idle_done", 32'(done2), 32'd0);
      check("idle_vec", {29'b0, a2, b2, c2}, 32'd0);
      check("idle_truth", 32'(truth2), 32'(m_truth));
`ifdef MYLOGIC_SWEEP_COMPARE_EN
      check("idle_mismatch", 32'(mismatch2), 32'(m_mm));
      check("idle_pass", 32'(pass2), 32'(m_pass));
`endif
      tick();
    end
  endtask

  initial begin
    int cnt[8];
    int last;
    bit order_ok;
    int len4;

    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_vec", {29'b0, a2, b2, c2}, 32'd0);
    check("rst_truth", 32'(truth2), 32'd0);
`ifdef MYLOGIC_SWEEP_COMPARE_EN
    check("rst_mismatch", 32'(mismatch2), 32'd0);
    check("rst_pass", 32'(pass2), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    sweep2(-1, 0, -1, 8'hEA);
    check("full_truth", 32'(truth2), 32'hEA);
`ifdef MYLOGIC_SWEEP_COMPARE_EN
    check("cmp_pass_ea", 32'(pass2), 32'd1);
    check("cmp_mm_ea", 32'(mismatch2), 32'd0);
    sweep2(-1, 0, -1, 8'hEB);
    check("cmp_pass_eb", 32'(pass2), 32'd0);
    check("cmp_mm_eb", 32'(mismatch2), 32'h01);
`endif

    sweep2(3 * (D2 + 1) + D2, 0, -1, 8'h00);
    check("abort_truth", 32'(truth2), 32'h0A);

    sweep2(-1, 40, -1, 8'hEA);
    check("noise_truth", 32'(truth2), 32'hEA);

    start2 = 1'b1;
    abort2 = 1'b1;
    tick();
    start2 = 1'b0;
    abort2 = 1'b0;
    check("sa_busy", 32'(busy2), 32'd0);
    check("sa_vec", {29'b0, a2, b2, c2}, 32'd0);
    tick();
    check("sa_busy2", 32'(busy2), 32'd0);

    sweep2(-1, 0, 10, 8'h00);
    check("post_rst_truth", 32'(truth2), 32'd0);
    sweep2(-1, 0, -1, 8'hEA);
    check("after_rst_truth", 32'(truth2), 32'hEA);

    len4 = NVEC * (D4 + 1);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int v = 0; v < 8; v++) cnt[v] = 0;
    last = 0;
    order_ok = 1'b1;
    for (int k = 0; k <= len4 + 1; k++) begin
      if (busy4) begin
        if (int'({a4, b4, c4}) < last) order_ok = 1'b0;
        last = int'({a4, b4, c4});
        cnt[{a4, b4, c4}]++;
      end
      if (k == len4) check("d4_done", 32'(done4), 32'd1);
      tick();
    end
    for (int v = 0; v < 8; v++) check($sformatf("d4_hold%0d", v), 32'(cnt[v]), 32'(D4 + 1));
    check("d4_order", 32'(order_ok), 32'd1);
    check("d4_truth", 32'(truth4), 32'hEA);
    check("d4_vec_end", {29'b0, a4, b4, c4}, 32'd0);

    rand_tbl = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tbl2 = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      sweep2(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NVEC * (D2 + 1) - 1)) : -1,
             25, -1, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
